// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - MDIO (clause 22) PHY-side frame responder
//
// Decodes MDIO management frames on the clk domain and answers reads or
// accepts writes addressed to PHY_ADDR.
// Optional macro: MDIO_PHY_RESPONDER_BROADCAST_EN (writes to PHYAD 0 accepted,
// reads to PHYAD 0 ignored).
//
// Ports:
//   clk        system clock, all logic on rising edge
//   reset      asynchronous active-high reset
//   mdc        management clock from the MAC (asynchronous)
//   mdio_in    sampled MDIO pad value
//   mdio_out   value to drive on MDIO
//   mdio_oen   active-low pad drive enable (1 = tristate)
//   reg_addr   captured REGAD, held until the next frame's REGAD
//   reg_wdata  captured write data
//   reg_wr     one-clk write strobe
//   reg_rd     one-clk read request strobe
//   reg_rdata  read data, valid the clk after reg_rd
//   frame_err  one-clk pulse on a malformed write TA addressed to this PHY

module mdio_phy_responder #(
   parameter logic [4:0] PHY_ADDR     = 5'd1,
   parameter int         MIN_PREAMBLE = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   output logic        mdio_oen,
   output logic [4:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_wr,
   output logic        reg_rd,
   input  logic [15:0] reg_rdata,
   output logic        frame_err
);

   localparam int              PW      = $clog2(MIN_PREAMBLE + 1);
   localparam logic [PW-1:0]   PRE_MAX = PW'(MIN_PREAMBLE);

   typedef enum logic [2:0] {
      S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA
   } state_t;

   state_t        state, state_nxt;
   logic          mdc_s1, mdc_s2, mdc_s3;
   logic          mdio_s1, mdio_s2;
   logic          mdc_edge;
   logic          bit_in;
   logic [PW-1:0] pre_cnt;
   logic [4:0]    cnt;
   logic [14:0]   sh;
   logic [15:0]   rd_sh;
   logic          is_read;
   logic          rd_load;
   logic [4:0]    field5;
   logic          addr_ok;

   assign mdc_edge = mdc_s2 & ~mdc_s3;
   assign bit_in   = mdio_s2;
   // Five most recent samples including the one taken on this edge event.
   assign field5   = {sh[3:0], bit_in};

`ifdef MDIO_PHY_RESPONDER_BROADCAST_EN
   assign addr_ok = (field5 == PHY_ADDR) || ((field5 == 5'd0) && !is_read);
`else
   assign addr_ok = (field5 == PHY_ADDR);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdc_s1  <= 1'b0;
         mdc_s2  <= 1'b0;
         mdc_s3  <= 1'b0;
         mdio_s1 <= 1'b1;
         mdio_s2 <= 1'b1;
      end else begin
         mdc_s1  <= mdc;
         mdc_s2  <= mdc_s1;
         mdc_s3  <= mdc_s2;
         mdio_s1 <= mdio_in;
         mdio_s2 <= mdio_s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (mdc_edge) begin
         case (state)
            S_IDLE:  if (!bit_in && pre_cnt >= PRE_MAX) state_nxt = S_ST;
            S_ST:    state_nxt = bit_in ? S_OP : S_IDLE;
            S_OP:    if (cnt == 5'd1)
                        state_nxt = (sh[0] != bit_in) ? S_PHYAD : S_IDLE;
            S_PHYAD: if (cnt == 5'd4) state_nxt = addr_ok ? S_REGAD : S_IDLE;
            S_REGAD: if (cnt == 5'd4) state_nxt = S_TA;
            S_TA:    if (is_read) state_nxt = S_RDATA;
                     else if (cnt == 5'd1)
                        state_nxt = ({sh[0], bit_in} == 2'b10) ? S_WDATA : S_IDLE;
            S_RDATA: if (cnt == 5'd16) state_nxt = S_IDLE;
            S_WDATA: if (cnt == 5'd15) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt   <= '0;
         cnt       <= '0;
         sh        <= '0;
         rd_sh     <= '0;
         is_read   <= 1'b0;
         rd_load   <= 1'b0;
         mdio_out  <= 1'b0;
         mdio_oen  <= 1'b1;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         frame_err <= 1'b0;
         rd_load   <= 1'b0;
         // Read data arrives the clk after reg_rd; no edge event can occur
         // that close to the REGAD edge given the clk/mdc ratio.
         if (rd_load) rd_sh <= reg_rdata;
         if (mdc_edge) begin
            sh  <= {sh[13:0], bit_in};
            cnt <= (state_nxt != state) ? 5'd0 : cnt + 5'd1;
            case (state)
               S_IDLE: begin
                  // A 0 always clears: either a broken preamble or frame entry.
                  if (!bit_in)               pre_cnt <= '0;
                  else if (pre_cnt < PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
               end
               S_OP: if (cnt == 5'd1) is_read <= ({sh[0], bit_in} == 2'b10);
               S_REGAD: if (cnt == 5'd4) begin
                  reg_addr <= field5;
                  if (is_read) begin
                     reg_rd  <= 1'b1;
                     rd_load <= 1'b1;
                  end
               end
               S_TA: begin
                  if (is_read) begin
                     mdio_oen <= 1'b0;
                     mdio_out <= 1'b0;
                  end else if (cnt == 5'd1 && {sh[0], bit_in} != 2'b10) begin
                     frame_err <= 1'b1;
                  end
               end
               S_RDATA: begin
                  if (cnt < 5'd16) begin
                     mdio_out <= rd_sh[15];
                     rd_sh    <= {rd_sh[14:0], 1'b0};
                  end else begin
                     mdio_oen <= 1'b1;
                     mdio_out <= 1'b0;
                  end
               end
               S_WDATA: if (cnt == 5'd15) begin
                  reg_wdata <= {sh, bit_in};
                  reg_wr    <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb/tb_mdio_phy_responder.sv - self-checking bench for mdio_phy_responder

module tb_mdio_phy_responder;

   localparam logic [4:0] PHY  = 5'd1;
   localparam int         MINP = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mdc = 1'b0;
   logic        mdio_in = 1'b1;
   logic        mdio_out, mdio_oen, reg_wr, reg_rd, frame_err;
   logic [4:0]  reg_addr;
   logic [15:0] reg_wdata, reg_rdata;
   logic [15:0] mem [32];

   int errors = 0;
   int checks = 0;
   int n_rd = 0, n_wr = 0, n_err = 0, n_both = 0, n_drv = 0;
   int b_rd, b_wr, b_err, b_both, b_drv;
   logic obs_oen [80];
   logic obs_out [80];
   logic exp_oen [80];
   logic exp_out [80];
   int   nbits;

   assign reg_rdata = mem[reg_addr];

   always #5 clk = ~clk;

   mdio_phy_responder #(.PHY_ADDR(PHY), .MIN_PREAMBLE(MINP)) dut (
      .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
      .mdio_out(mdio_out), .mdio_oen(mdio_oen), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .frame_err(frame_err)
   );

   always @(negedge clk) begin
      if (!reset) begin
         if (reg_rd) n_rd++;
         if (reg_wr) n_wr++;
         if (frame_err) n_err++;
         if (reg_rd && reg_wr) n_both++;
         if (!mdio_oen) n_drv++;
      end
   end

   // Frame-level reference: which strobes a frame should produce.
   function automatic void model(input int pre, input logic [1:0] op, input logic [4:0] phy,
                                 input logic [1:0] ta, output bit acc, output bit rd,
                                 output bit wr, output bit err);
      bit ok_addr;
      ok_addr = (phy == PHY);
`ifdef MDIO_PHY_RESPONDER_BROADCAST_EN
      if (phy == 5'd0 && op == 2'b01) ok_addr = 1'b1;
`endif
      acc = (pre >= MINP) && (op == 2'b10 || op == 2'b01) && ok_addr;
      rd  = acc && op == 2'b10;
      wr  = acc && op == 2'b01 && ta == 2'b10;
      err = acc && op == 2'b01 && ta != 2'b10;
   endfunction

   // Expected pad behaviour per MDC period: a read drives 17 periods starting
   // with the period of TA bit 1 (index pre+15 counting the leading 0).
   function automatic void model_drive(input int pre, input bit rd, input logic [15:0] d);
      for (int i = 0; i < 80; i++) begin
         exp_oen[i] = 1'b1;
         exp_out[i] = 1'b0;
      end
      if (rd) begin
         for (int k = 0; k <= 16; k++) begin
            exp_oen[pre + 15 + k] = 1'b0;
            exp_out[pre + 15 + k] = (k == 0) ? 1'b0 : d[16 - k];
         end
      end
   endfunction

   function automatic int drive_bad();
      int bad;
      bad = 0;
      for (int i = 0; i < nbits; i++)
         if (obs_oen[i] !== exp_oen[i] || (!exp_oen[i] && obs_out[i] !== exp_out[i]))
            bad++;
      return bad;
   endfunction

   task automatic mdc_bit(input logic b, input int idx);
      mdc = 1'b0;
      mdio_in = b;
      repeat (8) @(posedge clk);
      #1 mdc = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      obs_oen[idx] = mdio_oen;
      obs_out[idx] = mdio_out;
   endtask

   // Leading 0 clears any residual preamble count; two idle 1s trail.
   task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [1:0] ta,
                             input logic [15:0] wd, input int stop_at);
      logic q[$];
      b_rd = n_rd; b_wr = n_wr; b_err = n_err; b_both = n_both; b_drv = n_drv;
      q.push_back(1'b0);
      repeat (pre) q.push_back(1'b1);
      q.push_back(1'b0); q.push_back(1'b1);
      q.push_back(op[1]); q.push_back(op[0]);
      for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
      for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
      if (op == 2'b10) begin
         repeat (18) q.push_back(1'b1);
      end else begin
         q.push_back(ta[1]); q.push_back(ta[0]);
         for (int i = 15; i >= 0; i--) q.push_back(wd[i]);
      end
      q.push_back(1'b1); q.push_back(1'b1);
      nbits = q.size();
      for (int i = 0; i < q.size(); i++) begin
         if (stop_at >= 0 && i > stop_at) begin
            nbits = i;
            break;
         end
         mdc_bit(q[i], i);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mdio_oen !== 1'b1) begin errors++; $display("FAIL reset_oen: got %b expected 1", mdio_oen); end
      checks++;
      if (mdio_out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", mdio_out); end
      checks++;
      if (reg_addr !== 5'd0 || reg_wdata !== 16'd0) begin
         errors++; $display("FAIL reset_regs: got addr=%h wdata=%h expected 0/0", reg_addr, reg_wdata);
      end
      checks++;
      if ({reg_wr, reg_rd, frame_err} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes: got %b expected 000", {reg_wr, reg_rd, frame_err});
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_read_basic();
      mem[2] = 16'h0141;
      send_frame(32, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0, -1);
      model_drive(32, 1'b1, 16'h0141);
      checks++;
      if (n_rd - b_rd !== 1) begin errors++; $display("FAIL read_rd_count: got %0d expected 1", n_rd - b_rd); end
      checks++;
      if (reg_addr !== 5'h02) begin errors++; $display("FAIL read_addr: got %h expected 02", reg_addr); end
      checks++;
      if (drive_bad() !== 0) begin errors++; $display("FAIL read_drive: got %0d bad periods expected 0", drive_bad()); end
      checks++;
      if (n_wr - b_wr !== 0 || n_err - b_err !== 0) begin
         errors++; $display("FAIL read_no_wr_err: got wr=%0d err=%0d expected 0/0", n_wr - b_wr, n_err - b_err);
      end
   endtask

   task automatic test_write_basic();
      send_frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8000, -1);
      checks++;
      if (n_wr - b_wr !== 1) begin errors++; $display("FAIL write_wr_count: got %0d expected 1", n_wr - b_wr); end
      checks++;
      if (reg_wdata !== 16'h8000) begin errors++; $display("FAIL write_wdata: got %h expected 8000", reg_wdata); end
      checks++;
      if (n_drv - b_drv !== 0) begin errors++; $display("FAIL write_drive: got %0d driven clks expected 0", n_drv - b_drv); end
      checks++;
      if (n_rd - b_rd !== 0) begin errors++; $display("FAIL write_no_rd: got %0d expected 0", n_rd - b_rd); end
   endtask

   task automatic test_other_phy();
      send_frame(32, 2'b10, 5'd3, 5'd2, 2'b00, 16'h0, -1);
      checks++;
      if (n_rd - b_rd !== 0) begin errors++; $display("FAIL other_phy_rd: got %0d expected 0", n_rd - b_rd); end
      checks++;
      if (n_drv - b_drv !== 0) begin errors++; $display("FAIL other_phy_drive: got %0d expected 0", n_drv - b_drv); end
      checks++;
      if (n_err - b_err !== 0) begin errors++; $display("FAIL other_phy_err: got %0d expected 0", n_err - b_err); end
   endtask

   task automatic test_short_preamble();
      send_frame(31, 2'b01, 5'd1, 5'd7, 2'b10, 16'h1234, -1);
      checks++;
      if (n_wr - b_wr !== 0) begin errors++; $display("FAIL short_pre_wr: got %0d expected 0", n_wr - b_wr); end
      checks++;
      if (reg_wdata !== 16'h8000 || reg_addr !== 5'd0) begin
         errors++; $display("FAIL short_pre_regs: got addr=%h wdata=%h expected 00/8000", reg_addr, reg_wdata);
      end
   endtask

   task automatic test_bad_ta();
      send_frame(32, 2'b01, 5'd1, 5'd9, 2'b11, 16'h5555, -1);
      checks++;
      if (n_err - b_err !== 1) begin errors++; $display("FAIL bad_ta_err: got %0d expected 1", n_err - b_err); end
      checks++;
      if (n_wr - b_wr !== 0) begin errors++; $display("FAIL bad_ta_wr: got %0d expected 0", n_wr - b_wr); end
      checks++;
      if (reg_addr !== 5'd9) begin errors++; $display("FAIL bad_ta_addr: got %h expected 09", reg_addr); end
   endtask

   task automatic test_broadcast();
      bit acc, rd, wr, err;
      model(32, 2'b01, 5'd0, 2'b10, acc, rd, wr, err);
      send_frame(32, 2'b01, 5'd0, 5'd4, 2'b10, 16'hBEEF, -1);
      checks++;
      if (n_wr - b_wr !== int'(wr)) begin errors++; $display("FAIL bcast_wr: got %0d expected %0d", n_wr - b_wr, wr); end
      send_frame(32, 2'b10, 5'd0, 5'd4, 2'b00, 16'h0, -1);
      checks++;
      if (n_rd - b_rd !== 0 || n_drv - b_drv !== 0) begin
         errors++; $display("FAIL bcast_rd: got rd=%0d drv=%0d expected 0/0", n_rd - b_rd, n_drv - b_drv);
      end
   endtask

   task automatic test_reset_mid_read();
      mem[5] = 16'hA5C3;
      // Period pre+23 carries D8 (k=8 after the TA zero at pre+15).
      send_frame(32, 2'b10, 5'd1, 5'd5, 2'b00, 16'h0, 32 + 23);
      checks++;
      if (mdio_oen !== 1'b0) begin errors++; $display("FAIL mid_read_driving: got %b expected 0", mdio_oen); end
      #3 reset = 1'b1;
      #1;
      checks++;
      if (mdio_oen !== 1'b1) begin errors++; $display("FAIL mid_read_release: got %b expected 1", mdio_oen); end
      mdc = 1'b0;
      mdio_in = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      send_frame(32, 2'b10, 5'd1, 5'd5, 2'b00, 16'h0, -1);
      model_drive(32, 1'b1, 16'hA5C3);
      checks++;
      if (n_rd - b_rd !== 1) begin errors++; $display("FAIL after_reset_rd: got %0d expected 1", n_rd - b_rd); end
      checks++;
      if (drive_bad() !== 0) begin errors++; $display("FAIL after_reset_drive: got %0d bad periods expected 0", drive_bad()); end
   endtask

   task automatic test_random();
      logic [4:0]  e_addr;
      logic [15:0] e_wdata;
      e_addr  = 5'd5;
      e_wdata = 16'h0000;
      for (int it = 0; it < 20; it++) begin
         int          pre;
         logic [1:0]  op, ta;
         logic [4:0]  phy, ra;
         logic [15:0] wd;
         bit          acc, rd, wr, err;
         pre = $urandom_range(30, 34);
         op  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
         case ($urandom_range(0, 4))
            0, 1:    phy = PHY;
            2:       phy = 5'd3;
            3:       phy = 5'd0;
            default: phy = 5'($urandom);
         endcase
         ra = 5'($urandom);
         ta = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         wd = 16'($urandom);
         model(pre, op, phy, ta, acc, rd, wr, err);
         if (acc) e_addr = ra;
         if (wr)  e_wdata = wd;
         model_drive(pre, rd, mem[ra]);
         send_frame(pre, op, phy, ra, ta, wd, -1);
         checks++;
         if (n_rd - b_rd !== int'(rd) || n_wr - b_wr !== int'(wr) || n_err - b_err !== int'(err)) begin
            errors++;
            $display("FAIL rand%0d_strobes: got rd=%0d wr=%0d err=%0d expected %0d/%0d/%0d",
                     it, n_rd - b_rd, n_wr - b_wr, n_err - b_err, rd, wr, err);
         end
         checks++;
         if (n_both - b_both !== 0) begin errors++; $display("FAIL rand%0d_rd_wr_overlap: got %0d expected 0", it, n_both - b_both); end
         checks++;
         if (reg_addr !== e_addr || reg_wdata !== e_wdata) begin
            errors++;
            $display("FAIL rand%0d_regs: got addr=%h wdata=%h expected %h/%h", it, reg_addr, reg_wdata, e_addr, e_wdata);
         end
         checks++;
         if (drive_bad() !== 0) begin errors++; $display("FAIL rand%0d_drive: got %0d bad periods expected 0", it, drive_bad()); end
         checks++;
         if (!rd && n_drv - b_drv !== 0) begin errors++; $display("FAIL rand%0d_stray_drive: got %0d expected 0", it, n_drv - b_drv); end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      test_reset();
      test_read_basic();
      test_write_basic();
      test_other_phy();
      test_short_preamble();
      test_bad_ta();
      test_broadcast();
      test_reset_mid_read();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdio_phy_responder.md
MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: PHY address this responder answers to.
REQ-002 SHALL have parameter MIN_PREAMBLE, default 32: consecutive 1 bits required before ST.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port mdc, input, 1: management clock from the MAC; asynchronous to clk.
REQ-006 SHALL have port mdio_in, input, 1: sampled MDIO pad value.
REQ-007 SHALL have port mdio_out, output, 1: value to drive on MDIO.
REQ-008 SHALL have port mdio_oen, output, 1: active-low pad drive enable; 1 = tristate.
REQ-009 SHALL have port reg_addr, output, 5: captured REGAD; held until the next frame's REGAD.
REQ-010 SHALL have port reg_wdata, output, 16: captured write data.
REQ-011 SHALL have port reg_wr, output, 1: one-clk write strobe.
REQ-012 SHALL have port reg_rd, output, 1: one-clk read request strobe.
REQ-013 SHALL have port reg_rdata, input, 16: read data; valid the clk after reg_rd.
REQ-014 SHALL have port frame_err, output, 1: one-clk pulse on a malformed frame addressed to PHY_ADDR.

Function
REQ-015 SHALL synchronise mdc and mdio_in through two flops; an "edge event" is a one-clk pulse on a synchronised mdc 0->1 transition. clk SHALL be at least 8x the MDC frequency.
REQ-016 SHALL sample MDIO only on edge events; mdio_out/mdio_oen SHALL change only on the clk after an edge event.
REQ-017 SHALL implement states IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA.
REQ-018 IDLE: saturating preamble counter increments on a sampled 1 and clears on a sampled 0; a 0 with count >= MIN_PREAMBLE -> ST (this 0 is ST bit 1).
REQ-019 ST: sampled 1 -> OP; sampled 0 -> IDLE, counter cleared.
REQ-020 OP: 2 bits MSB first; 10 = read, 01 = write; 00/11 -> IDLE without frame_err.
REQ-021 PHYAD: 5 bits MSB first; on mismatch -> IDLE silently, never driving MDIO.
REQ-022 REGAD: 5 bits; on the edge event sampling bit 0, update reg_addr and go to TA; for reads, pulse reg_rd the same clk and load the read shift register from reg_rdata the following clk.
REQ-023 Read TA: stay tristate during TA bit 1; after the edge event that samples it, drive 0 (mdio_oen=0, mdio_out=0).
REQ-024 RDATA: on each of the next 16 edge events drive D15..D0 in turn; on the following edge event release (mdio_oen=1) -> IDLE. Total driven periods: 17.
REQ-025 Write TA: SHALL sample 1 then 0; any other pattern pulses frame_err -> IDLE.
REQ-026 WDATA: shift 16 bits MSB first; on the edge event sampling D0, update reg_wdata and pulse reg_wr the same clk -> IDLE.
REQ-027 The preamble counter SHALL clear on frame entry; a new frame needs a new full preamble (no back-to-back frames without preamble).
REQ-028 reg_wr and reg_rd SHALL never both be asserted in the same clk, and each SHALL pulse at most once per frame.

Reset
REQ-029 While reset is high: state IDLE, counters 0, mdio_oen=1, mdio_out=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, frame_err=0.
REQ-030 Reset asserted mid-read SHALL release MDIO immediately (asynchronously); after deassertion the block SHALL require a full preamble.

Configuration
REQ-031 Macro MDIO_PHY_RESPONDER_BROADCAST_EN: when defined, a write frame with PHYAD 0 SHALL be accepted as if addressed to PHY_ADDR, while a read frame with PHYAD 0 SHALL be ignored (never driven). When undefined, PHYAD 0 SHALL be treated like any other non-matching address.

Verification
REQ-032 32x1, ST 01, OP 10, PHYAD 1, REGAD 0x02, reg_rdata=0x0141 -> reg_rd one pulse, reg_addr=0x02, MDIO driven 0 then 0x0141 MSB first, released after 17 periods.
REQ-033 Full write to PHYAD 1, REGAD 0x00, data 0x8000 -> single reg_wr pulse, reg_wdata=0x8000, mdio_oen stays 1 throughout.
REQ-034 Read to PHYAD 3 -> no reg_rd, mdio_oen stays 1, frame_err stays 0.
REQ-035 31-bit preamble then valid write -> ignored, no reg_wr; write with TA=11 -> frame_err pulse, no reg_wr.
REQ-036 Assert reset during RDATA bit 8 -> mdio_oen=1 within the same clk as reset; next frame with full preamble is accepted normally.
REQ-037 With the macro defined: write to PHYAD 0 -> reg_wr pulse; read to PHYAD 0 -> no drive. Without the macro: both ignored.
